vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing_gen_if.sv | 18 +
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 83 ++++++++
 tb/tb_vga_timing_gen.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and the phase type used by both axis FSMs.
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 40;
    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Region of one axis: visible, front porch, sync pulse, back porch.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FPS = 2'd1,
        PH_SYN = 2'd2,
        PH_BPS = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: sync, data enable, pixel position and strobes.
interface vga_timing_gen_if;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       line_tick;
    logic       frame_tick;

    modport master (
        output hsync, vsync, de, sx, sy, line_tick, frame_tick
    );

    modport slave (
        input hsync, vsync, de, sx, sy, line_tick, frame_tick
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with a phase FSM that
// tracks which region (active/front porch/sync/back porch) the count is in.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output phase_t           phase
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYN = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

    // A 10-bit counter cannot represent longer axes; every region must be
    // non-empty or the phase FSM would skip a boundary.
    generate
        if (TOTAL > CNT_MAX) begin : g_total_too_long
            $error("vga_axis_counter: axis total exceeds 1024");
        end
        if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_empty_region
            $error("vga_axis_counter: every timing region must be at least 1");
        end
    endgenerate

    logic wrap;
    assign wrap = (count == LAST);

    // Counter and phase advance together so the phase always names the
    // region the current count lies in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            phase <= PH_ACT;
        end else if (adv) begin
            count <= wrap ? '0 : count + 1'b1;
            case (phase)
                PH_ACT:  if (count == LAST_ACT) phase <= PH_FPS;
                PH_FPS:  if (count == LAST_FP)  phase <= PH_SYN;
                PH_SYN:  if (count == LAST_SYN) phase <= PH_BPS;
                PH_BPS:  if (wrap)              phase <= PH_ACT;
                default: phase <= PH_ACT;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters with
// registered sync, data enable, position and line/frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  bus
);

    localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_LEN - 1);
    localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;

    assign h_wrap = (h_count == H_LAST);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (1'b1),
        .count (h_count),
        .phase (h_phase)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (h_wrap),
        .count (v_count),
        .phase (v_phase)
    );

    // Register every output from the current counter state (one clock latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sx         <= '0;
            bus.sy         <= '0;
            bus.de         <= 1'b0;
            bus.hsync      <= ~HS_POL;
            bus.vsync      <= ~VS_POL;
            bus.line_tick  <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.sx         <= h_count;
            bus.sy         <= v_count;
            bus.de         <= (h_phase == PH_ACT) && (v_phase == PH_ACT);
            bus.hsync      <= (h_phase == PH_SYN) ? HS_POL : ~HS_POL;
            bus.vsync      <= (v_phase == PH_SYN) ? VS_POL : ~VS_POL;
            bus.line_tick  <= h_wrap;
            // Start of vertical blanking: last clock of the last visible line.
            bus.frame_tick <= h_wrap && (v_count == V_LAST_ACT);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench: default build, a small-timing active-low build and a
// small-timing active-high build, all checked against a position model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] sx;
        logic [9:0] sy;
        logic       lt;
        logic       ft;
    } vout_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n = 0;   // clock edges seen since reset release

    always #5 clk = ~clk;

    vga_timing_gen_if bus_d ();
    vga_timing_gen_if bus_s ();
    vga_timing_gen_if bus_p ();

    vga_timing_gen dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (3), .V_BP (4)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (3), .V_BP (4),
        .HS_POL (1'b1), .VS_POL (1'b1)
    ) dut_p (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p)
    );

    // Reference: position in frame is (edges-1) mod frame length; every
    // output follows from that position by the timing rules.
    function automatic vout_t ref_out(int ha, int hf, int hw, int hb,
                                      int va, int vf, int vw, int vb,
                                      logic hp, logic vp, int edges);
        vout_t o;
        int ht, vt, pos, hc, vc;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        if (edges <= 0) begin
            o = '0;
            o.hs = ~hp;
            o.vs = ~vp;
            return o;
        end
        pos  = (edges - 1) % (ht * vt);
        hc   = pos % ht;
        vc   = pos / ht;
        o.sx = 10'(hc);
        o.sy = 10'(vc);
        o.de = (hc < ha) && (vc < va);
        o.hs = (hc >= ha + hf && hc < ha + hf + hw) ? hp : ~hp;
        o.vs = (vc >= va + vf && vc < va + vf + vw) ? vp : ~vp;
        o.lt = (hc == ht - 1);
        o.ft = (hc == ht - 1) && (vc == va - 1);
        return o;
    endfunction

    function automatic vout_t exp_d();
        return ref_out(800, 40, 48, 40, 480, 13, 3, 29, 1'b0, 1'b0, n);
    endfunction
    function automatic vout_t exp_s();
        return ref_out(16, 4, 6, 6, 12, 2, 3, 4, 1'b0, 1'b0, n);
    endfunction
    function automatic vout_t exp_p();
        return ref_out(16, 4, 6, 6, 12, 2, 3, 4, 1'b1, 1'b1, n);
    endfunction

    function automatic vout_t got_d();
        return {bus_d.hsync, bus_d.vsync, bus_d.de, bus_d.sx, bus_d.sy, bus_d.line_tick, bus_d.frame_tick};
    endfunction
    function automatic vout_t got_s();
        return {bus_s.hsync, bus_s.vsync, bus_s.de, bus_s.sx, bus_s.sy, bus_s.line_tick, bus_s.frame_tick};
    endfunction
    function automatic vout_t got_p();
        return {bus_p.hsync, bus_p.vsync, bus_p.de, bus_p.sx, bus_p.sy, bus_p.line_tick, bus_p.frame_tick};
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        n = 0;
        step();
        step();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        vout_t g, e;
        rst_n = 1'b0;
        n = 0;
        repeat (3) step();
        g = got_d(); e = exp_d(); checks++;
        if (g !== e) begin failures++; $display("FAIL reset_d got=%h exp=%h", g, e); end
        g = got_s(); e = exp_s(); checks++;
        if (g !== e) begin failures++; $display("FAIL reset_s got=%h exp=%h", g, e); end
        g = got_p(); e = exp_p(); checks++;
        if (g !== e) begin failures++; $display("FAIL reset_p got=%h exp=%h", g, e); end
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus_d.sx !== 10'd0 || bus_d.sy !== 10'd0 || bus_d.de !== 1'b1) begin
            failures++;
            $display("FAIL first_out got sx=%0d sy=%0d de=%b exp sx=0 sy=0 de=1", bus_d.sx, bus_d.sy, bus_d.de);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_line_default();
        vout_t g, e;
        int de_cnt = 0, de_min = 1023, de_max = -1;
        int lt_cnt = 0, lt_sx = -1;
        int hs_cnt = 0, hs_min = 1023, hs_max = -1;
        int errs = 0;
        apply_reset();
        for (int i = 0; i < 928; i++) begin
            step();
            g = got_d(); e = exp_d();
            checks++;
            if (g !== e) begin
                failures++; errs++;
                $display("FAIL line_d step=%0d got=%h exp=%h", i, g, e);
            end
            if (g.de === 1'b1) begin
                de_cnt++;
                if (int'(g.sx) < de_min) de_min = int'(g.sx);
                if (int'(g.sx) > de_max) de_max = int'(g.sx);
            end
            if (g.lt === 1'b1) begin lt_cnt++; lt_sx = int'(g.sx); end
            if (g.hs === 1'b0) begin
                hs_cnt++;
                if (int'(g.sx) < hs_min) hs_min = int'(g.sx);
                if (int'(g.sx) > hs_max) hs_max = int'(g.sx);
            end
        end
        checks++;
        if (de_cnt != 800 || de_min != 0 || de_max != 799) begin
            failures++;
            $display("FAIL de_window got cnt=%0d sx=%0d..%0d exp cnt=800 sx=0..799", de_cnt, de_min, de_max);
        end
        checks++;
        if (lt_cnt != 1 || lt_sx != 927) begin
            failures++;
            $display("FAIL line_tick got cnt=%0d sx=%0d exp cnt=1 sx=927", lt_cnt, lt_sx);
        end
        checks++;
        if (hs_cnt != 48 || hs_min != 840 || hs_max != 887) begin
            failures++;
            $display("FAIL hsync_pulse got cnt=%0d sx=%0d..%0d exp cnt=48 sx=840..887", hs_cnt, hs_min, hs_max);
        end
        $display("test_line_default done step_errors=%0d", errs);
    endtask

    task automatic test_frame_small();
        vout_t g, e, gp, ep, prev;
        int ft_cnt = 0, ft_sx = -1, ft_sy = -1;
        int vs_cnt = 0, vs_min = 1023, vs_max = -1;
        int de_blank = 0, wraps = 0, wrap_bad = 0;
        int ph_cnt = 0, ph_min = 1023;
        int errs = 0;
        prev = '0;
        apply_reset();
        for (int i = 0; i < 672 * 3 + 5; i++) begin
            step();
            g = got_s(); e = exp_s();
            gp = got_p(); ep = exp_p();
            checks++;
            if (g !== e) begin
                failures++; errs++;
                $display("FAIL frame_s step=%0d got=%h exp=%h", i, g, e);
            end
            checks++;
            if (gp !== ep) begin
                failures++; errs++;
                $display("FAIL frame_p step=%0d got=%h exp=%h", i, gp, ep);
            end
            if (i < 672) begin
                if (g.ft === 1'b1) begin ft_cnt++; ft_sx = int'(g.sx); ft_sy = int'(g.sy); end
                if (g.vs === 1'b0) begin
                    vs_cnt++;
                    if (int'(g.sy) < vs_min) vs_min = int'(g.sy);
                    if (int'(g.sy) > vs_max) vs_max = int'(g.sy);
                end
                if (g.de === 1'b1 && g.sy >= 10'd12) de_blank++;
            end
            if (i < 32 && gp.hs === 1'b1) begin
                ph_cnt++;
                if (int'(gp.sx) < ph_min) ph_min = int'(gp.sx);
            end
            if (i > 0 && g.sx === 10'd0 && g.sy === 10'd0) begin
                wraps++;
                if (prev.sx !== 10'd31 || prev.sy !== 10'd20 || prev.lt !== 1'b1 || prev.ft !== 1'b0)
                    wrap_bad++;
            end
            prev = g;
        end
        checks++;
        if (ft_cnt != 1 || ft_sx != 31 || ft_sy != 11) begin
            failures++;
            $display("FAIL frame_tick got cnt=%0d at (%0d,%0d) exp cnt=1 at (31,11)", ft_cnt, ft_sx, ft_sy);
        end
        checks++;
        if (vs_cnt != 96 || vs_min != 14 || vs_max != 16) begin
            failures++;
            $display("FAIL vsync_pulse got cnt=%0d sy=%0d..%0d exp cnt=96 sy=14..16", vs_cnt, vs_min, vs_max);
        end
        checks++;
        if (de_blank != 0) begin
            failures++;
            $display("FAIL de_vblank got=%0d exp=0", de_blank);
        end
        checks++;
        if (wraps != 3 || wrap_bad != 0) begin
            failures++;
            $display("FAIL frame_wrap got wraps=%0d bad=%0d exp wraps=3 bad=0", wraps, wrap_bad);
        end
        checks++;
        if (ph_cnt != 6 || ph_min != 20) begin
            failures++;
            $display("FAIL hsync_high_pol got cnt=%0d start=%0d exp cnt=6 start=20", ph_cnt, ph_min);
        end
        $display("test_frame_small done step_errors=%0d", errs);
    endtask

    task automatic test_mid_reset_fixed();
        vout_t g, e;
        apply_reset();
        repeat (203) step();
        checks++;
        if (bus_s.sx !== 10'd10 || bus_s.sy !== 10'd6) begin
            failures++;
            $display("FAIL mid_pos got (%0d,%0d) exp (10,6)", bus_s.sx, bus_s.sy);
        end
        #2;
        rst_n = 1'b0;
        n = 0;
        #1;
        g = got_s(); e = exp_s(); checks++;
        if (g !== e) begin failures++; $display("FAIL async_reset_s got=%h exp=%h", g, e); end
        g = got_d(); e = exp_d(); checks++;
        if (g !== e) begin failures++; $display("FAIL async_reset_d got=%h exp=%h", g, e); end
        repeat (2) begin
            step();
            g = got_p(); e = exp_p(); checks++;
            if (g !== e) begin failures++; $display("FAIL hold_reset_p got=%h exp=%h", g, e); end
        end
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus_s.sx !== 10'd0 || bus_s.sy !== 10'd0 || bus_s.de !== 1'b1) begin
            failures++;
            $display("FAIL restart got sx=%0d sy=%0d de=%b exp sx=0 sy=0 de=1", bus_s.sx, bus_s.sy, bus_s.de);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            g = got_s(); e = exp_s(); checks++;
            if (g !== e) begin failures++; $display("FAIL after_restart step=%0d got=%h exp=%h", i, g, e); end
        end
        $display("test_mid_reset_fixed done");
    endtask

    task automatic test_random_reset();
        vout_t g, e;
        int k, dly, hold;
        for (int r = 0; r < 4; r++) begin
            k    = int'($urandom_range(1, 3000));
            dly  = int'($urandom_range(1, 7));
            hold = int'($urandom_range(1, 3));
            apply_reset();
            for (int i = 0; i < k; i++) begin
                step();
                g = got_d(); e = exp_d(); checks++;
                if (g !== e) begin failures++; $display("FAIL rnd_d run=%0d step=%0d got=%h exp=%h", r, i, g, e); end
                g = got_s(); e = exp_s(); checks++;
                if (g !== e) begin failures++; $display("FAIL rnd_s run=%0d step=%0d got=%h exp=%h", r, i, g, e); end
                g = got_p(); e = exp_p(); checks++;
                if (g !== e) begin failures++; $display("FAIL rnd_p run=%0d step=%0d got=%h exp=%h", r, i, g, e); end
            end
            #(dly);
            rst_n = 1'b0;
            n = 0;
            #1;
            g = got_d(); e = exp_d(); checks++;
            if (g !== e) begin failures++; $display("FAIL rnd_async_d run=%0d got=%h exp=%h", r, g, e); end
            g = got_p(); e = exp_p(); checks++;
            if (g !== e) begin failures++; $display("FAIL rnd_async_p run=%0d got=%h exp=%h", r, g, e); end
            repeat (hold) step();
            #2;
            rst_n = 1'b1;
            for (int i = 0; i < 50; i++) begin
                step();
                g = got_d(); e = exp_d(); checks++;
                if (g !== e) begin failures++; $display("FAIL rnd_restart_d run=%0d step=%0d got=%h exp=%h", r, i, g, e); end
            end
            $display("random run %0d len=%0d reset_delay=%0d hold=%0d done", r, k, dly, hold);
        end
    endtask

    initial begin
        test_reset();
        test_line_default();
        test_frame_small();
        test_mid_reset_fixed();
        test_random_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
